// File: rtl/memsys_pkg.sv
// rtl/memsys_pkg.sv - shared types for the snoop bus arbiter
//
// Purpose : arbiter FSM state encoding shared by the arbiter RTL and its bench.
// Ports   : none (package).
package memsys_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT  = 2'd1,
    ARB_ACTIVE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bus_rr_picker.sv
// rtl/bus_rr_picker.sv - combinational rotate-priority encoder
//
// Purpose : picks the first set request bit starting at ptr_i and wrapping
//           modulo num_p.
// Ports   : req_i   [num_p]      request vector
//           ptr_i   [id_width_p] highest-priority index (must be < num_p)
//           valid_o              any request set
//           id_o    [id_width_p] winning index (0 when valid_o=0)
module bus_rr_picker #(
  parameter int num_p      = 2,
  parameter int id_width_p = 1
) (
  input  logic [num_p-1:0]      req_i,
  input  logic [id_width_p-1:0] ptr_i,
  output logic                  valid_o,
  output logic [id_width_p-1:0] id_o
);

  int               idx;
  logic [num_p-1:0] req_sh;

  // Scan from lowest to highest priority so the last hit written is the
  // highest-priority one; avoids an early-exit construct.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    idx     = 0;
    req_sh  = '0;
    for (int i = num_p - 1; i >= 0; i--) begin
      idx = int'(ptr_i) + i;
      if (idx >= num_p) begin
        idx = idx - num_p;
      end
      req_sh = req_i >> idx;
      if (req_sh[0]) begin
        valid_o = 1'b1;
        id_o    = id_width_p'(idx);
      end
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// rtl/snoop_bus_arbiter.sv - round-robin snoop bus arbiter with watchdog
//
// Purpose : shares the snooping bus among num_caches_p snoop controllers.
//           One grant per bus transaction, held until tx_done_i; a watchdog
//           frees a hung bus and latches a sticky error.
// Ports   : clk_i       clock, rising edge
//           nreset_i    asynchronous active-low reset
//           req_i       [num_caches_p] level requests
//           tx_done_i   transaction complete pulse (only honoured in ACTIVE)
//           grant_o     [num_caches_p] one-hot grant, held GRANT..ACTIVE
//           grant_id_o  [id_width_lp] current/last winner
//           tx_begin_o  transaction start pulse, only in GRANT
//           busy_o      state != IDLE
//           error_o     sticky watchdog expiry
module snoop_bus_arbiter
  import memsys_pkg::*;
#(
  parameter  int num_caches_p = 2,
  parameter  int timeout_p    = 256,
  localparam int id_width_lp  = (num_caches_p > 1) ? $clog2(num_caches_p) : 1
) (
  input  logic                    clk_i,
  input  logic                    nreset_i,
  input  logic [num_caches_p-1:0] req_i,
  input  logic                    tx_done_i,
  output logic [num_caches_p-1:0] grant_o,
  output logic [id_width_lp-1:0]  grant_id_o,
  output logic                    tx_begin_o,
  output logic                    busy_o,
  output logic                    error_o
);

  localparam int wdog_width_lp = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;
  localparam logic [wdog_width_lp-1:0] wdog_last_lp =
    wdog_width_lp'((timeout_p > 0) ? timeout_p - 1 : 0);
  localparam logic [id_width_lp-1:0] last_id_lp = id_width_lp'(num_caches_p - 1);

  arb_state_e                state_q,    state_d;
  logic [id_width_lp-1:0]    rr_ptr_q,   rr_ptr_d;
  logic [id_width_lp-1:0]    grant_id_q, grant_id_d;
  logic [num_caches_p-1:0]   grant_q,    grant_d;
  logic                      busy_q,     busy_d;
  logic                      error_q,    error_d;
  logic [wdog_width_lp-1:0]  wdog_cnt_q, wdog_cnt_d;

  logic [num_caches_p-1:0]   pick_req;
  logic [id_width_lp-1:0]    pick_ptr;
  logic                      pick_valid;
  logic [id_width_lp-1:0]    pick_id;
  logic [id_width_lp-1:0]    next_ptr;
  logic                      winner_req;
  logic                      wdog_expire;

  // Pointer that follows the current winner, wrapping at num_caches_p-1.
  assign next_ptr    = (grant_id_q == last_id_lp) ? '0 : grant_id_q + id_width_lp'(1);
  // grant_q is one-hot on the winner whenever it matters, so this selects req_i[id].
  assign winner_req  = |(req_i & grant_q);
  assign wdog_expire = (timeout_p != 0) && (wdog_cnt_q == wdog_last_lp);

  // One picker serves both arbitration points: plain requests from the stored
  // pointer in IDLE, and in ACTIVE the other controllers' requests from the
  // post-transaction pointer (the current winner's own request is masked).
  always_comb begin
    if (state_q == ARB_ACTIVE) begin
      pick_req = req_i & ~grant_q;
      pick_ptr = next_ptr;
    end else begin
      pick_req = req_i;
      pick_ptr = rr_ptr_q;
    end
  end

  bus_rr_picker #(
    .num_p      (num_caches_p),
    .id_width_p (id_width_lp)
  ) u_picker (
    .req_i   (pick_req),
    .ptr_i   (pick_ptr),
    .valid_o (pick_valid),
    .id_o    (pick_id)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    error_d    = error_q;
    wdog_cnt_d = wdog_cnt_q;
    grant_d    = '0;
    busy_d     = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d    = ARB_GRANT;
          grant_id_d = pick_id;
        end
      end

      ARB_GRANT: begin
        if (winner_req) begin
          state_d    = ARB_ACTIVE;
          wdog_cnt_d = '0;
        end else begin
          // Withdrawn request: give up the slot without moving the pointer.
          state_d = ARB_IDLE;
        end
      end

      ARB_ACTIVE: begin
        if (wdog_cnt_q != '1) begin
          wdog_cnt_d = wdog_cnt_q + wdog_width_lp'(1);
        end
        // tx_done_i takes precedence over a same-cycle watchdog expiry.
        if (tx_done_i) begin
          rr_ptr_d = next_ptr;
          if (pick_valid) begin
            state_d    = ARB_GRANT;
            grant_id_d = pick_id;
          end else begin
            state_d = ARB_IDLE;
          end
        end else if (wdog_expire) begin
          error_d  = 1'b1;
          rr_ptr_d = next_ptr;
          state_d  = ARB_IDLE;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    busy_d = (state_d != ARB_IDLE);
    for (int i = 0; i < num_caches_p; i++) begin
      grant_d[i] = busy_d && (grant_id_d == id_width_lp'(i));
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      wdog_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
      wdog_cnt_q <= wdog_cnt_d;
    end
  end

  assign grant_o    = grant_q;
  assign grant_id_o = grant_id_q;
  assign busy_o     = busy_q;
  assign error_o    = error_q;
  // The start pulse must vanish when the winner withdraws during GRANT, so it
  // is qualified by the live request rather than registered ahead of time.
  assign tx_begin_o = (state_q == ARB_GRANT) && winner_req;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb/tb_snoop_bus_arbiter.sv - self-checking bench for snoop_bus_arbiter
module tb_snoop_bus_arbiter;
  import memsys_pkg::*;

  logic       clk = 1'b0;
  logic       nreset_i;
  logic [3:0] req_i;
  logic       tx_done_i;
  logic [3:0] grant_o;
  logic [1:0] grant_id_o;
  logic       tx_begin_o;
  logic       busy_o;
  logic       error_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] id;
    logic       txb;
    logic       busy;
    logic       err;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic       done;
    exp_t       e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];

  snoop_bus_arbiter #(
    .num_caches_p (4),
    .timeout_p    (16)
  ) dut (
    .clk_i      (clk),
    .nreset_i   (nreset_i),
    .req_i      (req_i),
    .tx_done_i  (tx_done_i),
    .grant_o    (grant_o),
    .grant_id_o (grant_id_o),
    .tx_begin_o (tx_begin_o),
    .busy_o     (busy_o),
    .error_o    (error_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  function automatic exp_t mk(input logic [3:0] g, input logic [1:0] id,
                              input logic t, input logic b, input logic e);
    exp_t x;
    x.grant = g; x.id = id; x.txb = t; x.busy = b; x.err = e;
    return x;
  endfunction

  task automatic addv(input logic [3:0] r, input logic d, input exp_t e);
    vec_t v;
    v.req = r; v.done = d; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
  endtask

  task automatic check_out(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      cmp({nm, ".scoreboard_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    cmp({nm, ".grant"},    32'(grant_o),    32'(e.grant));
    cmp({nm, ".grant_id"}, 32'(grant_id_o), 32'(e.id));
    cmp({nm, ".tx_begin"}, 32'(tx_begin_o), 32'(e.txb));
    cmp({nm, ".busy"},     32'(busy_o),     32'(e.busy));
    cmp({nm, ".error"},    32'(error_o),    32'(e.err));
    cmp({nm, ".onehot0"},  32'($onehot0(grant_o)), 32'd1);
    cmp({nm, ".busy_state"}, 32'(busy_o), 32'(dut.state_q != ARB_IDLE));
    if (tx_begin_o) cmp({nm, ".txb_state"}, 32'(dut.state_q), 32'(ARB_GRANT));
  endtask

  task automatic step(input logic [3:0] r, input logic d, input exp_t e, input string nm);
    @(negedge clk);
    req_i     = r;
    tx_done_i = d;
    sb.push_back(e);
    #1;
    check_out(nm);
  endtask

  initial begin
    exp_t e_idle0;
    nreset_i  = 1'b0;
    req_i     = 4'hF;
    tx_done_i = 1'b0;
    e_idle0   = mk(4'h0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Single requester, pointer check, withdraw, round robin: one record per cycle.
    addv(4'h4, 0, mk(4'h0, 2'd0, 0, 0, 0));
    addv(4'h4, 0, mk(4'h4, 2'd2, 1, 1, 0));
    for (int i = 0; i < 4; i++) addv(4'h4, 0, mk(4'h4, 2'd2, 0, 1, 0));
    addv(4'h4, 1, mk(4'h4, 2'd2, 0, 1, 0));
    addv(4'h0, 0, mk(4'h0, 2'd2, 0, 0, 0));
    addv(4'hC, 0, mk(4'h0, 2'd2, 0, 0, 0));
    addv(4'hC, 0, mk(4'h8, 2'd3, 1, 1, 0));
    addv(4'h0, 1, mk(4'h8, 2'd3, 0, 1, 0));
    addv(4'h0, 0, mk(4'h0, 2'd3, 0, 0, 0));
    addv(4'h2, 0, mk(4'h0, 2'd3, 0, 0, 0));
    addv(4'h0, 0, mk(4'h2, 2'd1, 0, 1, 0));
    addv(4'hA, 0, mk(4'h0, 2'd1, 0, 0, 0));
    addv(4'hA, 0, mk(4'h2, 2'd1, 1, 1, 0));
    addv(4'hA, 1, mk(4'h2, 2'd1, 0, 1, 0));
    addv(4'hA, 1, mk(4'h8, 2'd3, 1, 1, 0));
    addv(4'h0, 1, mk(4'h8, 2'd3, 0, 1, 0));
    addv(4'h0, 1, mk(4'h0, 2'd3, 0, 0, 0));
    addv(4'hF, 0, mk(4'h0, 2'd3, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      logic [3:0] g;
      g = 4'h1 << k;
      addv(4'hF, 0, mk(g, 2'(k), 1, 1, 0));
      addv(4'hF, 0, mk(g, 2'(k), 0, 1, 0));
      addv(4'hF, 0, mk(g, 2'(k), 0, 1, 0));
      addv(4'hF, 1, mk(g, 2'(k), 0, 1, 0));
    end
    addv(4'hF, 0, mk(4'h1, 2'd0, 1, 1, 0));
    addv(4'h0, 1, mk(4'h1, 2'd0, 0, 1, 0));
    addv(4'h0, 0, mk(4'h0, 2'd0, 0, 0, 0));

    // Reset held with all requests set.
    step(4'hF, 0, e_idle0, "reset_a");
    step(4'hF, 0, e_idle0, "reset_b");
    @(negedge clk);
    req_i    = 4'h0;
    nreset_i = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].req, vecs[i].done, vecs[i].e, $sformatf("vec%0d", i));
    end

    // Watchdog expiry on id 3; pointer then favours 0.
    step(4'h8, 0, mk(4'h0, 2'd0, 0, 0, 0), "wd_idle");
    step(4'h8, 0, mk(4'h8, 2'd3, 1, 1, 0), "wd_grant");
    for (int k = 0; k < 15; k++) step(4'h8, 0, mk(4'h8, 2'd3, 0, 1, 0), $sformatf("wd_act%0d", k));
    step(4'h9, 0, mk(4'h8, 2'd3, 0, 1, 0), "wd_act15");
    step(4'h9, 0, mk(4'h0, 2'd3, 0, 0, 1), "wd_expired");
    step(4'h9, 0, mk(4'h1, 2'd0, 1, 1, 1), "wd_next0");
    step(4'h0, 1, mk(4'h1, 2'd0, 0, 1, 1), "wd_done");
    step(4'h0, 0, mk(4'h0, 2'd0, 0, 0, 1), "wd_sticky");

    // Async reset in ACTIVE: grant drops with no clock edge.
    step(4'h2, 0, mk(4'h0, 2'd0, 0, 0, 1), "ar_idle");
    step(4'h2, 0, mk(4'h2, 2'd1, 1, 1, 1), "ar_grant");
    step(4'h2, 0, mk(4'h2, 2'd1, 0, 1, 1), "ar_active");
    #1;
    nreset_i = 1'b0;
    sb.push_back(e_idle0);
    #1;
    check_out("ar_async");
    req_i = 4'h0;
    @(negedge clk);
    nreset_i = 1'b1;

    // After reset: 4'b0011 grants 0; tx_done on 16th ACTIVE cycle avoids error.
    step(4'h3, 0, mk(4'h0, 2'd0, 0, 0, 0), "td_idle");
    step(4'h3, 0, mk(4'h1, 2'd0, 1, 1, 0), "td_grant");
    for (int k = 0; k < 15; k++) step(4'h3, 0, mk(4'h1, 2'd0, 0, 1, 0), $sformatf("td_act%0d", k));
    step(4'h0, 1, mk(4'h1, 2'd0, 0, 1, 0), "td_act15");
    step(4'h0, 0, mk(4'h0, 2'd0, 0, 0, 0), "td_noerr");
    step(4'h0, 0, mk(4'h0, 2'd0, 0, 0, 0), "td_noerr2");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
